fp_norm_round_pack: RTL and testbench

// - Final stage of the FPU add/sub datapath. Sits downstream of the mantissa adder and the sign logic.
// - Takes the result sign, the biased exponent of the larger operand, and the raw mantissa sum
//   (carry, hidden bit, fraction, G/R/S).
// - Normalises the sum: a 1-bit right shift on carry, otherwise iterative left shifts of one bit per cycle.
// - Rounds round-to-nearest-even, packs an IEEE-754 word and raises status flags.
// - Single-entry buffer with a valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fp_round_rne.sv | 21 ++
 rtl/fp_norm_round_pack.sv | 145 ++++++++++++++
 tb/tb_fp_norm_round_pack.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared widths, bit positions and FSM encoding for the FPU add/sub back end.
package fpu_pkg;

   localparam int unsigned EXP_BITS  = 8;
   localparam int unsigned MANT_BITS = 23;
   localparam int unsigned MW        = MANT_BITS + 5;
   localparam int unsigned RW        = 1 + EXP_BITS + MANT_BITS;

   localparam int unsigned BIAS = (1 << (EXP_BITS - 1)) - 1;
   // Exponents are carried one bit wider so +1/-1 never wrap.
   localparam logic [EXP_BITS:0] EXP_MAX = (EXP_BITS + 1)'(2 * BIAS + 1);
   localparam logic [EXP_BITS:0] EXP_ONE = (EXP_BITS + 1)'(1);

   localparam int unsigned S_BIT      = 0;
   localparam int unsigned R_BIT      = 1;
   localparam int unsigned G_BIT      = 2;
   localparam int unsigned LSB_BIT    = 3;
   localparam int unsigned HIDDEN_BIT = MW - 2;
   localparam int unsigned CARRY_BIT  = MW - 1;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StRound,
      StDone
   } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on {hidden, frac, G, R, S}; purely combinational.
module fp_round_rne
   import fpu_pkg::*;
(
   input  logic [MW-2:0]    mant,
   output logic [MANT_BITS:0] rounded,
   output logic             carry,
   output logic             inexact
);

   logic [MANT_BITS:0] hf;
   logic               round_up;

   always_comb begin
      hf       = mant[HIDDEN_BIT:LSB_BIT];
      round_up = mant[G_BIT] & (mant[R_BIT] | mant[S_BIT] | hf[0]);
      {carry, rounded} = {1'b0, hf} + (MANT_BITS + 2)'(round_up);
      inexact  = mant[G_BIT] | mant[R_BIT] | mant[S_BIT];
   end

endmodule

// File: rtl/fp_norm_round_pack.sv
// Normalise, round (RNE) and pack the raw add/sub mantissa sum into an IEEE-754 word,
// behind a single-entry valid/ready buffer.
module fp_norm_round_pack
   import fpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [EXP_BITS-1:0] in_exp,
   input  logic [MW-1:0]       in_mant,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RW-1:0]       out_result,
   output logic                out_overflow,
   output logic                out_inexact,
   output logic                out_zero
);

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [EXP_BITS:0] exp_q, exp_d;
   logic [MW-2:0]     mant_q, mant_d;   // carry bit is folded away on accept
   logic [RW-1:0]     result_q, result_d;
   logic              ovf_q, ovf_d, inx_q, inx_d, zero_q, zero_d;

   logic [MANT_BITS:0] rounded;
   logic               rnd_carry, rnd_inexact;
   logic [EXP_BITS:0]  exp_rnd;

   fp_round_rne u_round (
      .mant    (mant_q),
      .rounded (rounded),
      .carry   (rnd_carry),
      .inexact (rnd_inexact)
   );

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      inx_d    = inx_q;
      zero_d   = zero_q;

      if (rnd_carry) begin
         exp_rnd = exp_q + EXP_ONE;
      end else if (exp_q == '0 && rounded[MANT_BITS]) begin
         exp_rnd = EXP_ONE;
      end else begin
         exp_rnd = exp_q;
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d = in_sign;
               exp_d  = {1'b0, in_exp};
               if (in_mant == '0) begin
                  result_d = {in_sign, {(RW - 1){1'b0}}};
                  ovf_d    = 1'b0;
                  inx_d    = 1'b0;
                  zero_d   = 1'b1;
                  state_d  = StDone;
               end else if (in_mant[CARRY_BIT]) begin
                  mant_d  = {in_mant[CARRY_BIT:G_BIT], in_mant[R_BIT] | in_mant[S_BIT]};
                  exp_d   = {1'b0, in_exp} + EXP_ONE;
                  state_d = StRound;
               end else begin
                  mant_d  = in_mant[HIDDEN_BIT:0];
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            if (mant_q[HIDDEN_BIT]) begin
               state_d = StRound;
            end else if (exp_q <= EXP_ONE) begin
               exp_d   = '0;
               state_d = StRound;
            end else begin
               mant_d = {mant_q[HIDDEN_BIT-1:0], 1'b0};
               exp_d  = exp_q - EXP_ONE;
               // Leave as soon as the shift lands a one in the hidden position.
               if (mant_q[HIDDEN_BIT-1]) begin
                  state_d = StRound;
               end
            end
         end
         StRound: begin
            inx_d  = rnd_inexact;
            ovf_d  = 1'b0;
            zero_d = 1'b0;
            if (exp_rnd >= EXP_MAX) begin
               result_d = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
               ovf_d    = 1'b1;
               inx_d    = 1'b1;
            end else begin
               result_d = {sign_q, exp_rnd[EXP_BITS-1:0], rounded[MANT_BITS-1:0]};
               zero_d   = (exp_rnd == '0) && (rounded == '0);
            end
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         inx_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         inx_q    <= inx_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready     = (state_q == StIdle) && rst_n;
   assign out_valid    = (state_q == StDone);
   assign out_result   = result_q;
   assign out_overflow = ovf_q;
   assign out_inexact  = inx_q;
   assign out_zero     = zero_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Randomised and directed bench for fp_norm_round_pack against an arithmetic reference model.
module tb_fp_norm_round_pack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_inexact;
   logic        out_zero;

   int n_checks = 0;
   int n_fail   = 0;

   fp_norm_round_pack dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_mant      (in_mant),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_inexact  (out_inexact),
      .out_zero     (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        inx;
      logic        zero;
      int          lat;
   } model_t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Value-level model: mantissa as an integer, exponent as a plain int.
   function automatic model_t model(input bit s, input int e_in, input longint unsigned m_in);
      model_t          r;
      longint unsigned m = m_in;
      longint unsigned sig, rem;
      int              e = e_in;
      int              shifts = 0;
      bit              up;
      r.ovf  = 1'b0;
      r.inx  = 1'b0;
      r.zero = 1'b0;
      if (m == 0) begin
         r.res  = {s, 31'b0};
         r.zero = 1'b1;
         r.lat  = 1;
         return r;
      end
      if (m >= (64'd1 << 27)) begin
         m = (m >> 1) | (m & 64'd1);
         e = e + 1;
         r.lat = 2;
      end else begin
         while (m < (64'd1 << 26) && e > 1) begin
            m = m * 2;
            e = e - 1;
            shifts++;
         end
         if (m < (64'd1 << 26)) begin
            e = 0;
            r.lat = 3 + shifts;
         end else begin
            r.lat = 2 + ((shifts == 0) ? 1 : shifts);
         end
      end
      sig = m >> 3;
      rem = m & 64'd7;
      up  = (rem > 4) || (rem == 4 && sig[0]);
      sig = sig + longint'(up);
      if (sig == (64'd1 << 24)) begin
         sig = 64'd1 << 23;
         e   = e + 1;
      end else if (e == 0 && sig >= (64'd1 << 23)) begin
         e = 1;
      end
      r.inx = (rem != 0);
      if (e >= 255) begin
         r.res = {s, 8'hFF, 23'b0};
         r.ovf = 1'b1;
         r.inx = 1'b1;
      end else begin
         r.res  = {s, 8'(e), 23'(sig)};
         r.zero = (r.res[30:0] == 31'b0);
      end
      return r;
   endfunction

   task automatic run_op(input string tag, input bit s, input logic [7:0] e,
                         input logic [27:0] m, input int hold,
                         output logic [31:0] got_res, output int got_lat);
      model_t want;
      int     wait_cnt;
      want = model(s, int'(e), longint'(m));
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      got_lat  = 1;
      while (!out_valid && got_lat < 200) begin
         @(posedge clk);
         #1;
         got_lat++;
      end
      got_res = out_result;
      check({tag, "_result"}, 64'(out_result), 64'(want.res));
      check({tag, "_overflow"}, 64'(out_overflow), 64'(want.ovf));
      check({tag, "_inexact"}, 64'(out_inexact), 64'(want.inx));
      check({tag, "_zero"}, 64'(out_zero), 64'(want.zero));
      check({tag, "_latency"}, 64'(got_lat), 64'(want.lat));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_result"}, 64'(out_result), 64'(want.res));
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_released"}, 64'(out_valid), 64'd0);
   endtask

   typedef struct {
      string       tag;
      bit          s;
      logic [7:0]  e;
      logic [27:0] m;
      logic [31:0] res;
      int          lat;
      int          hold;
   } dir_t;

   dir_t dirs[$];

   initial begin
      logic [31:0] got_res;
      int          got_lat;
      int          rises;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_result", 64'(out_result), 64'd0);
      check("rst_flags", 64'({out_overflow, out_inexact, out_zero}), 64'd0);
      rst_n = 1'b1;

      dirs.push_back('{"carry",     1'b0, 8'h7F, 28'h8000000, 32'h40000000, 2,  0});
      dirs.push_back('{"cancel",    1'b0, 8'h7F, 28'h0000008, 32'h34000000, 25, 0});
      dirs.push_back('{"subnormal", 1'b0, 8'h01, 28'h2000000, 32'h00400000, 3,  0});
      dirs.push_back('{"rne_even",  1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3,  5});
      dirs.push_back('{"rne_odd",   1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 3,  0});
      dirs.push_back('{"ovf_carry", 1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 2,  0});
      dirs.push_back('{"ovf_round", 1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 3,  0});
      dirs.push_back('{"zero",      1'b1, 8'h55, 28'h0000000, 32'h80000000, 1,  0});
      foreach (dirs[i]) begin
         run_op(dirs[i].tag, dirs[i].s, dirs[i].e, dirs[i].m, dirs[i].hold, got_res, got_lat);
         check({dirs[i].tag, "_const_result"}, 64'(got_res), 64'(dirs[i].res));
         check({dirs[i].tag, "_const_latency"}, 64'(got_lat), 64'(dirs[i].lat));
      end

      for (int n = 0; n < 150; n++) begin
         bit          s;
         logic [7:0]  e;
         logic [27:0] m;
         int          p;
         s = 1'($urandom);
         e = 8'($urandom_range(1, 254));
         if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 30));
         p = $urandom_range(1, 28);
         m = 28'($urandom & ((32'd1 << p) - 1)) | 28'(32'd1 << (p - 1));
         if ($urandom_range(0, 15) == 0) m = '0;
         run_op("rand", s, e, m, $urandom_range(0, 2), got_res, got_lat);
      end

      // Reset in the middle of a long normalisation.
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'h7F;
      in_mant  = 28'h0000008;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_result", 64'(out_result), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      rises = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) rises++;
      end
      check("aborted_beat_dropped", 64'(rises), 64'd0);
      run_op("after_rst", 1'b0, 8'h7F, 28'h4000004, 0, got_res, got_lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
